// File: rtl/popcount_neuron_sched.sv
// ============================================================================
// Module   : popcount_neuron_sched
// Purpose  : Time-shares one external 25-input popcount across the positive
//            and negative weight masks of a chunked ternary neuron.
// Revision : 1.0
// ============================================================================
`default_nettype none

module popcount_neuron_sched #(
  parameter int NUM_CHUNKS = 4,
  parameter int ACC_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [24:0]      input_a,
  input  logic [24:0]      wpos,
  input  logic [24:0]      wneg,
  input  logic [ACC_W-1:0] thresh,
  output logic [24:0]      pc_in,
  input  logic [4:0]       pc_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] neuron_sum,
  output logic             neuron_act,
  output logic             busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_POS  = 2'd1;
  localparam logic [1:0] S_NEG  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Four bits cover the full 1..16 chunk range.
  localparam int             CNT_W    = 4;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CHUNKS - 1);

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [CNT_W-1:0] r_chunk_cnt;
  logic [ACC_W-1:0] r_pos_acc;
  logic [ACC_W-1:0] r_neg_acc;
  logic [ACC_W-1:0] r_thr;
  logic [24:0]      r_x;
  logic [24:0]      r_wpos;
  logic [24:0]      r_wneg;

  logic [ACC_W-1:0] w_pc_ext;
  logic [ACC_W-1:0] w_neg_sum;
  logic [ACC_W-1:0] w_diff;
  logic             w_last;

  // Approximate popcounts may report up to 31; the value is used unmodified.
  assign w_pc_ext  = {{(ACC_W-5){1'b0}}, pc_out};
  assign w_neg_sum = r_neg_acc + w_pc_ext;
  assign w_diff    = r_pos_acc - w_neg_sum;
  assign w_last    = (r_chunk_cnt == LAST_CNT);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_next_state = S_POS;
      S_POS:   w_next_state = S_NEG;
      S_NEG:   w_next_state = w_last ? S_DONE : S_IDLE;
      S_DONE:  if (out_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready = 1'b0;
    pc_in    = 25'd0;
    busy     = 1'b1;
    case (r_state)
      S_IDLE: begin
        in_ready = ~rst;
        busy     = (r_chunk_cnt != '0);
      end
      S_POS:   pc_in = r_x & r_wpos;
      S_NEG:   pc_in = r_x & r_wneg;
      default: begin
        in_ready = 1'b0;
        pc_in    = 25'd0;
      end
    endcase
  end

  // Datapath: operand capture, accumulation and registered result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_chunk_cnt <= '0;
      r_pos_acc   <= '0;
      r_neg_acc   <= '0;
      r_thr       <= '0;
      r_x         <= '0;
      r_wpos      <= '0;
      r_wneg      <= '0;
      out_valid   <= 1'b0;
      neuron_sum  <= '0;
      neuron_act  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_x    <= input_a;
            r_wpos <= wpos;
            r_wneg <= wneg;
            if (r_chunk_cnt == '0) r_thr <= thresh;
          end
        end
        S_POS: begin
          r_pos_acc <= r_pos_acc + w_pc_ext;
        end
        S_NEG: begin
          r_neg_acc <= w_neg_sum;
          if (w_last) begin
            // Result uses the final negative count directly so DONE can present it at once.
            out_valid  <= 1'b1;
            neuron_sum <= w_diff;
            neuron_act <= ($signed(w_diff) >= $signed(r_thr));
          end else begin
            r_chunk_cnt <= r_chunk_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_pos_acc   <= '0;
            r_neg_acc   <= '0;
            r_chunk_cnt <= '0;
            out_valid   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
